matrix_vector_mac: RTL and testbench
====================================

MATRIX_VECTOR_MAC -- requirements
Module: matrix_vector_mac

Interface
REQ-001 Parameter ROWS, default 3, output vector length (>=1).
REQ-002 Parameter COLS, default 3, input vector length (>=1).
REQ-003 Parameter BITS, default 16, signed two's-complement weight width.
REQ-004 Parameter IN_W, default 4, unsigned input element width.
REQ-005 Derived localparam OUT_W = IN_W + BITS + $clog2(COLS) + 1; default 23; not overridable.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 w_we  input  1  weight write strobe.
REQ-010 w_row  input  $clog2(ROWS) (min 1)  weight row index.
REQ-011 w_col  input  $clog2(COLS) (min 1)  weight column index.
REQ-012 w_data  input  BITS  signed weight value.
REQ-013 in_valid  input  1  input vector valid.
REQ-014 in_ready  output  1  block can accept an input vector.
REQ-015 input_vector  input  IN_W x COLS (unpacked [0:COLS-1])  unsigned input elements.
REQ-016 out_valid  output  1  output vector valid.
REQ-017 out_ready  input  1  downstream accepts output.
REQ-018 output_vector  output  OUT_W x ROWS (unpacked [0:ROWS-1])  signed results.
REQ-019 busy  output  1  high in COMPUTE or OUTPUT state.

Function
REQ-020 Weight store: ROWS x COLS registers, BITS each; written on clk when w_we=1 and state=IDLE; w_we in any other state is ignored.
REQ-021 Out-of-range w_row/w_col (>=ROWS/COLS) writes are ignored.
REQ-022 FSM states IDLE, COMPUTE, OUTPUT; IDLE->COMPUTE on in_valid&in_ready; COMPUTE->OUTPUT after exactly COLS cycles; OUTPUT->IDLE on out_valid&out_ready.
REQ-023 in_ready = 1 only in IDLE; on acceptance input_vector is latched; later input changes have no effect.
REQ-024 Simultaneous w_we and input acceptance in IDLE: the write takes effect before the first MAC cycle.
REQ-025 Entry to COMPUTE clears all ROWS accumulators and column counter to 0.
REQ-026 COMPUTE cycle c (0..COLS-1): acc[r] += signed(W[r][c]) * zero-extended(x[c]) for all r in parallel; one column per cycle.
REQ-027 Products and sums are sign-extended to OUT_W; no overflow possible at any parameter setting; no saturation or truncation.
REQ-028 Latency: out_valid rises COLS+1 clock edges after the acceptance edge (COLS compute edges plus one transition edge).
REQ-029 In OUTPUT, output_vector and out_valid hold stable until out_ready=1; out_valid is registered.
REQ-030 Throughput: at most one vector per COLS+2 cycles; no overlap of computations.
REQ-031 output_vector holds the last result in IDLE/COMPUTE; only out_valid qualifies it.

Reset
REQ-032 rst_n=0 asynchronously forces: state IDLE, in_ready=1 after release, out_valid=0, busy=0, output_vector=0, accumulators=0, all weights=0.
REQ-033 Reset mid-COMPUTE or mid-OUTPUT aborts the operation; no out_valid is produced for the aborted vector.

Verification
REQ-034 W=[[1,2,3],[4,5,6],[7,8,9]], x=[1,2,3], out_ready=1 -> output [14,32,50], out_valid 4 edges after acceptance.
REQ-035 W[0][0]=-32768, other weights 0, x=[15,0,0] -> output[0]=-491520, output[1]=output[2]=0.
REQ-036 All weights 32767, x=[15,15,15] -> each output 1474515; all weights -32768 -> each -1474560 (no overflow).
REQ-037 out_ready=0 for 5 cycles in OUTPUT -> out_valid and output_vector stable, in_ready=0, second in_valid not accepted until handshake.
REQ-038 w_we during COMPUTE changing W[0][0] -> current result unchanged; next vector uses old weight.
REQ-039 rst_n pulsed low during COMPUTE -> out_valid stays 0, weights zeroed, in_ready=1 after release; next vector gives all-zero output.

Source files
------------

// File: rtl/matrix_vector_mac_if.sv
// Bundle of weight-load, input-vector and output-vector handshake signals
// for matrix_vector_mac; the master side drives weights and input vectors.
interface matrix_vector_mac_if #(
    parameter int ROWS = 3,
    parameter int COLS = 3,
    parameter int BITS = 16,
    parameter int IN_W = 4
);
    localparam int OUT_W = IN_W + BITS + $clog2(COLS) + 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic                    w_we;
    logic [ROW_W-1:0]        w_row;
    logic [COL_W-1:0]        w_col;
    logic signed [BITS-1:0]  w_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [IN_W-1:0]         input_vector [0:COLS-1];
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] output_vector [0:ROWS-1];
    logic                    busy;

    modport master (
        output w_we, w_row, w_col, w_data, in_valid, input_vector, out_ready,
        input  in_ready, out_valid, output_vector, busy
    );

    modport slave (
        input  w_we, w_row, w_col, w_data, in_valid, input_vector, out_ready,
        output in_ready, out_valid, output_vector, busy
    );
endinterface

// File: rtl/matrix_vector_mac.sv
// Signed-weight x unsigned-vector multiply-accumulate: one column per cycle,
// all rows in parallel, result held in a registered output vector.
module matrix_vector_mac #(
    parameter int ROWS = 3,
    parameter int COLS = 3,
    parameter int BITS = 16,
    parameter int IN_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    matrix_vector_mac_if.slave  bus
);
    localparam int OUT_W = IN_W + BITS + $clog2(COLS) + 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W = $clog2(COLS + 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg;
    logic [IN_W-1:0]         x_reg   [0:COLS-1];
    logic signed [BITS-1:0]  w_reg   [0:ROWS-1][0:COLS-1];
    logic signed [OUT_W-1:0] acc_reg [0:ROWS-1];
    logic signed [OUT_W-1:0] out_reg [0:ROWS-1];
    logic                    accept, mac_en, done;
    logic [COL_W-1:0]        col_sel;
    logic signed [OUT_W-1:0] x_ext;

    assign accept  = (state_reg == IDLE) && bus.in_valid;
    assign mac_en  = (state_reg == COMPUTE) && (cnt_reg != CNT_W'(COLS));
    assign done    = (state_reg == COMPUTE) && (cnt_reg == CNT_W'(COLS));
    assign col_sel = cnt_reg[COL_W-1:0];
    // Input elements are unsigned: zero-extend before the signed multiply.
    assign x_ext   = $signed({{(OUT_W-IN_W){1'b0}}, x_reg[col_sel]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid)  state_next = COMPUTE;
            COMPUTE: if (done)          state_next = OUTPUT;
            OUTPUT:  if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_reg == IDLE);
        bus.busy      = (state_reg != IDLE);
        bus.out_valid = (state_reg == OUTPUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            for (int i = 0; i < COLS; i++) x_reg[i] <= '0;
        end else if (accept) begin
            cnt_reg <= '0;
            for (int i = 0; i < COLS; i++) x_reg[i] <= bus.input_vector[i];
        end else if (mac_en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            logic signed [OUT_W-1:0] w_ext;
            logic signed [OUT_W-1:0] prod;

            // Rows/columns with no matching index never fire, so
            // out-of-range addresses are dropped without extra logic.
            for (gj = 0; gj < COLS; gj++) begin : g_col
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        w_reg[gi][gj] <= '0;
                    else if ((state_reg == IDLE) && bus.w_we &&
                             (bus.w_row == ROW_W'(gi)) && (bus.w_col == COL_W'(gj)))
                        w_reg[gi][gj] <= bus.w_data;
                end
            end

            assign w_ext = OUT_W'(w_reg[gi][col_sel]);
            assign prod  = w_ext * x_ext;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      acc_reg[gi] <= '0;
                else if (accept) acc_reg[gi] <= '0;
                else if (mac_en) acc_reg[gi] <= acc_reg[gi] + prod;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    out_reg[gi] <= '0;
                else if (done) out_reg[gi] <= acc_reg[gi];
            end

            assign bus.output_vector[gi] = out_reg[gi];
        end
    endgenerate
endmodule

// File: tb/tb_matrix_vector_mac.sv
// Directed bench for matrix_vector_mac with hand-computed result vectors.
module tb_matrix_vector_mac;
    localparam int ROWS = 3;
    localparam int COLS = 3;
    localparam int BITS = 16;
    localparam int IN_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_vector_mac_if #(.ROWS(ROWS), .COLS(COLS), .BITS(BITS), .IN_W(IN_W)) mvm();

    matrix_vector_mac #(.ROWS(ROWS), .COLS(COLS), .BITS(BITS), .IN_W(IN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mvm)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_w(input int r, input int c, input int v);
        mvm.w_we   = 1'b1;
        mvm.w_row  = 2'(r);
        mvm.w_col  = 2'(c);
        mvm.w_data = 16'(v);
        @(posedge clk);
        @(negedge clk);
        mvm.w_we   = 1'b0;
    endtask

    task automatic load_seq();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                write_w(r, c, r * COLS + c + 1);
    endtask

    task automatic load_all(input int v);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                write_w(r, c, v);
    endtask

    // Called at a negedge in IDLE; returns at the negedge after acceptance
    // with the input bus scrambled to prove the vector was latched.
    task automatic send(input int x0, input int x1, input int x2,
                        input bit do_w, input int wd);
        mvm.input_vector[0] = 4'(x0);
        mvm.input_vector[1] = 4'(x1);
        mvm.input_vector[2] = 4'(x2);
        mvm.in_valid = 1'b1;
        if (do_w) begin
            mvm.w_we = 1'b1; mvm.w_row = 2'd0; mvm.w_col = 2'd0; mvm.w_data = 16'(wd);
        end
        @(posedge clk);
        @(negedge clk);
        mvm.in_valid = 1'b0;
        mvm.w_we     = 1'b0;
        for (int i = 0; i < COLS; i++) mvm.input_vector[i] = 4'd9;
    endtask

    task automatic wait_result(input string tag, input int pre,
                               input int e0, input int e1, input int e2);
        int edges;
        edges = pre;
        while (!mvm.out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, "_latency"}, edges, COLS + 1);
        check({tag, "_out0"}, mvm.output_vector[0], e0);
        check({tag, "_out1"}, mvm.output_vector[1], e1);
        check({tag, "_out2"}, mvm.output_vector[2], e2);
        check({tag, "_in_ready"}, int'(mvm.in_ready), 0);
        check({tag, "_busy"}, int'(mvm.busy), 1);
        $display("vector %s: out=[%0d,%0d,%0d] latency=%0d", tag,
                 mvm.output_vector[0], mvm.output_vector[1], mvm.output_vector[2], edges);
    endtask

    task automatic ack(input string tag);
        mvm.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ack_valid"}, int'(mvm.out_valid), 0);
        check({tag, "_ack_ready"}, int'(mvm.in_ready), 1);
        check({tag, "_ack_busy"}, int'(mvm.busy), 0);
    endtask

    initial begin
        int seen;
        mvm.w_we = 1'b0; mvm.w_row = '0; mvm.w_col = '0; mvm.w_data = '0;
        mvm.in_valid = 1'b0; mvm.out_ready = 1'b1;
        for (int i = 0; i < COLS; i++) mvm.input_vector[i] = '0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(mvm.in_ready), 1);
        check("rst_out_valid", int'(mvm.out_valid), 0);
        check("rst_busy", int'(mvm.busy), 0);
        check("rst_out0", mvm.output_vector[0], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 3x3 product; out-of-range writes must not disturb anything
        load_seq();
        write_w(3, 0, 999);
        write_w(0, 3, 999);
        send(1, 2, 3, 1'b0, 0);
        wait_result("basic", 0, 14, 32, 50);
        ack("basic");

        load_all(0);
        write_w(0, 0, -32768);
        send(15, 0, 0, 1'b0, 0);
        wait_result("minw", 0, -491520, 0, 0);
        ack("minw");

        load_all(32767);
        send(15, 15, 15, 1'b0, 0);
        wait_result("maxpos", 0, 1474515, 1474515, 1474515);
        ack("maxpos");

        load_all(-32768);
        send(15, 15, 15, 1'b0, 0);
        wait_result("maxneg", 0, -1474560, -1474560, -1474560);
        ack("maxneg");

        // Backpressure with a second vector waiting
        load_seq();
        mvm.out_ready = 1'b0;
        send(1, 1, 1, 1'b0, 0);
        wait_result("bp", 0, 6, 15, 24);
        mvm.in_valid = 1'b1;
        mvm.input_vector[0] = 4'd2; mvm.input_vector[1] = 4'd0; mvm.input_vector[2] = 4'd0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_valid", int'(mvm.out_valid), 1);
            check("bp_hold_out0", mvm.output_vector[0], 6);
            check("bp_hold_out2", mvm.output_vector[2], 24);
            check("bp_hold_in_ready", int'(mvm.in_ready), 0);
        end
        mvm.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_ready", int'(mvm.in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        mvm.in_valid = 1'b0;
        for (int i = 0; i < COLS; i++) mvm.input_vector[i] = 4'd9;
        wait_result("bp2", 0, 2, 8, 14);
        ack("bp2");

        // Weight write during COMPUTE is ignored
        send(1, 0, 0, 1'b0, 0);
        mvm.w_we = 1'b1; mvm.w_row = 2'd0; mvm.w_col = 2'd0; mvm.w_data = 16'd100;
        @(posedge clk);
        @(negedge clk);
        mvm.w_we = 1'b0;
        wait_result("wcomp", 1, 1, 4, 7);
        ack("wcomp");
        send(1, 0, 0, 1'b0, 0);
        wait_result("wold", 0, 1, 4, 7);
        ack("wold");

        // Write coinciding with acceptance lands before the first MAC
        send(1, 0, 0, 1'b1, 5);
        wait_result("wsim", 0, 5, 4, 7);
        ack("wsim");

        // Reset in the middle of COMPUTE
        send(1, 1, 1, 1'b0, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", int'(mvm.out_valid), 0);
        check("abort_busy", int'(mvm.busy), 0);
        check("abort_in_ready", int'(mvm.in_ready), 1);
        check("abort_out0", mvm.output_vector[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (mvm.out_valid) seen++;
        end
        check("abort_no_valid", seen, 0);
        check("abort_ready_after", int'(mvm.in_ready), 1);
        send(1, 2, 3, 1'b0, 0);
        wait_result("post_rst", 0, 0, 0, 0);
        ack("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
